// File: rtl/block_scheduler.sv
// Block scheduler: splits a kernel launch into fixed-size thread blocks
// and hands them to free compute cores, tracking completion and run time.
module block_scheduler #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 16,
  parameter int BLOCK_ID_BITS     = 8,
  parameter int CYCLE_BITS        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [THREAD_COUNT_BITS-1:0] thread_count,
  input  logic [NUM_CORES-1:0]         core_done,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NUM_CORES-1:0]         core_reset,
  output logic [BLOCK_ID_BITS-1:0]     core_block_id [NUM_CORES],
  output logic [$clog2(THREADS_PER_BLOCK):0]
                                       core_thread_count [NUM_CORES],
  output logic                         done,
  output logic                         busy,
  output logic                         aborted,
  output logic [CYCLE_BITS-1:0]        kernel_cycles
);

  localparam int SH = $clog2(THREADS_PER_BLOCK);
  localparam int CW = SH + 1;
  localparam int W  = THREAD_COUNT_BITS + 1;

  typedef logic [W-1:0] cnt_t;

  localparam cnt_t ONE      = cnt_t'(1);
  localparam cnt_t TPB_W    = cnt_t'(THREADS_PER_BLOCK);
  localparam cnt_t REM_MASK = cnt_t'(THREADS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  logic [THREAD_COUNT_BITS-1:0] tc_q;
  cnt_t total_blocks;
  cnt_t next_block;
  cnt_t blocks_done;

  cnt_t launch_blocks;
  cnt_t nb_nx;
  cnt_t fin;
  cnt_t blocks_done_nx;
  cnt_t rem;

  logic [NUM_CORES-1:0] give;
  cnt_t                 gid  [NUM_CORES];
  logic [CW-1:0]        gcnt [NUM_CORES];

  // ceil(count / block) as shift plus a partial-block bump
  always_comb begin
    launch_blocks = (cnt_t'(thread_count) >> SH)
                  + (((cnt_t'(thread_count) & REM_MASK) != '0) ? ONE : '0);
  end

  // Lower-index cores claim the lower block ids within one cycle
  always_comb begin
    nb_nx = next_block;
    fin   = '0;
    rem   = '0;
    give  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      gid[i]  = nb_nx;
      gcnt[i] = '0;
      if (core_reset[i]) begin
        if (nb_nx < total_blocks) begin
          give[i] = 1'b1;
          rem     = {1'b0, tc_q} - (nb_nx << SH);
          gcnt[i] = (rem >= TPB_W) ? CW'(THREADS_PER_BLOCK)
                                   : rem[CW-1:0];
          nb_nx   = nb_nx + ONE;
        end
      end else if (core_start[i] && core_done[i]) begin
        fin = fin + ONE;
      end
    end
    blocks_done_nx = blocks_done + fin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      tc_q          <= '0;
      total_blocks  <= '0;
      next_block    <= '0;
      blocks_done   <= '0;
      core_start    <= '0;
      core_reset    <= '1;
      done          <= 1'b0;
      busy          <= 1'b0;
      aborted       <= 1'b0;
      kernel_cycles <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_block_id[i]     <= '0;
        core_thread_count[i] <= '0;
      end
    end else begin
      aborted <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        core_start <= '0;
        core_reset <= '1;
        done       <= 1'b0;
        busy       <= 1'b0;
        aborted    <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            core_reset <= '1;
            core_start <= '0;
            done       <= 1'b0;
            if (start) begin
              tc_q          <= thread_count;
              total_blocks  <= launch_blocks;
              next_block    <= '0;
              blocks_done   <= '0;
              kernel_cycles <= '0;
              if (launch_blocks == '0) begin
                state <= S_DONE;
              end else begin
                state <= S_RUN;
                busy  <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (kernel_cycles != '1)
              kernel_cycles <= kernel_cycles + CYCLE_BITS'(1);
            for (int i = 0; i < NUM_CORES; i++) begin
              if (core_reset[i]) begin
                core_reset[i] <= 1'b0;
                if (give[i]) begin
                  core_start[i]        <= 1'b1;
                  core_block_id[i]     <= BLOCK_ID_BITS'(gid[i]);
                  core_thread_count[i] <= gcnt[i];
                end
              end else if (core_start[i] && core_done[i]) begin
                core_start[i] <= 1'b0;
                core_reset[i] <= 1'b1;
              end
            end
            next_block  <= nb_nx;
            blocks_done <= blocks_done_nx;
            if (blocks_done_nx == total_blocks) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              core_start <= '0;
              core_reset <= '1;
            end
          end
          S_DONE: begin
            core_reset <= '1;
            core_start <= '0;
            if (start) begin
              done <= 1'b1;
            end else begin
              done  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_scheduler.sv
// Bench for block_scheduler: directed launches plus randomized core
// latencies, checked against block-level arithmetic expectations.
module tb_block_scheduler;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TCB = 16;
  localparam int BIB = 8;
  localparam int CB  = 32;
  localparam int CW  = $clog2(TPB) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           abort;
  logic [TCB-1:0] thread_count;
  logic [NC-1:0]  core_done;
  logic [NC-1:0]  core_start;
  logic [NC-1:0]  core_reset;
  logic [BIB-1:0] core_block_id [NC];
  logic [CW-1:0]  core_thread_count [NC];
  logic           done;
  logic           busy;
  logic           aborted;
  logic [CB-1:0]  kernel_cycles;

  int checks = 0;
  int fails  = 0;

  int issued;
  int completed;
  int busy_cnt;
  int done_at;
  int assign_at [64];

  always #5 clk = ~clk;

  block_scheduler #(
    .NUM_CORES(NC),
    .THREADS_PER_BLOCK(TPB),
    .THREAD_COUNT_BITS(TCB),
    .BLOCK_ID_BITS(BIB),
    .CYCLE_BITS(CB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .thread_count(thread_count),
    .core_done(core_done),
    .core_start(core_start),
    .core_reset(core_reset),
    .core_block_id(core_block_id),
    .core_thread_count(core_thread_count),
    .done(done),
    .busy(busy),
    .aborted(aborted),
    .kernel_cycles(kernel_cycles)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_idle_outputs(input string tag);
    checks++;
    if (core_reset !== '1 || core_start !== '0 || done !== 1'b0 ||
        busy !== 1'b0 || aborted !== 1'b0 || kernel_cycles !== '0) begin
      fails++;
      $display("FAIL %s: rst=%b st=%b done=%b busy=%b ab=%b kc=%0d, want 11 00 0 0 0 0",
               tag, core_reset, core_start, done, busy, aborted, kernel_cycles);
    end
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (core_block_id[i] !== '0 || core_thread_count[i] !== '0) begin
        fails++;
        $display("FAIL %s core%0d: id=%0d cnt=%0d, want 0 0",
                 tag, i, core_block_id[i], core_thread_count[i]);
      end
    end
  endtask

  // Full launch: bench acts as the cores, then does the start/done handshake
  task automatic run_launch(input int n, input int lat0, input int lat1,
                            input bit rnd);
    int nblk;
    int id;
    int exp_cnt;
    int cnt [NC];
    bit run [NC];
    bit pend [NC];
    bit fin;
    nblk      = (n + TPB - 1) / TPB;
    issued    = 0;
    completed = 0;
    busy_cnt  = 0;
    done_at   = -1;
    fin       = 1'b0;
    for (int i = 0; i < NC; i++) begin
      run[i]  = 1'b0;
      pend[i] = 1'b0;
      cnt[i]  = 0;
    end
    thread_count = TCB'(n);
    start        = 1'b1;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      thread_count = TCB'($urandom);
      if (busy) busy_cnt++;
      core_done = '0;
      for (int i = 0; i < NC; i++) begin
        if (pend[i]) begin
          checks++;
          if (core_reset[i] !== 1'b1 || core_start[i] !== 1'b0) begin
            fails++;
            $display("FAIL free_core%0d: rst=%b st=%b, want 1 0",
                     i, core_reset[i], core_start[i]);
          end
          pend[i] = 1'b0;
        end
        if (core_start[i] && !run[i]) begin
          id = int'(core_block_id[i]);
          checks++;
          if (id !== issued || issued >= nblk) begin
            fails++;
            $display("FAIL block_order core%0d: id=%0d, want %0d of %0d",
                     i, id, issued, nblk);
          end
          exp_cnt = n - issued * TPB;
          if (exp_cnt > TPB) exp_cnt = TPB;
          checks++;
          if (core_thread_count[i] !== CW'(exp_cnt)) begin
            fails++;
            $display("FAIL block_threads id%0d: got %0d, want %0d",
                     issued, core_thread_count[i], exp_cnt);
          end
          assign_at[issued % 64] = cyc;
          issued++;
          run[i] = 1'b1;
          cnt[i] = rnd ? int'($urandom_range(0, 3)) : ((i == 0) ? lat0 : lat1);
        end else if (run[i]) begin
          cnt[i]--;
        end
        if (run[i] && cnt[i] <= 0) begin
          core_done[i] = 1'b1;
          run[i]       = 1'b0;
          pend[i]      = 1'b1;
          completed++;
        end else if (rnd && !core_start[i]) begin
          core_done[i] = 1'($urandom);
        end
      end
      if (done) begin
        fin       = 1'b1;
        done_at   = cyc;
        core_done = '0;
      end
    end
    checks++;
    if (!fin) begin
      fails++;
      $display("FAIL launch_timeout n=%0d: done never seen", n);
    end
    checks++;
    if (issued !== nblk || completed !== nblk) begin
      fails++;
      $display("FAIL block_total n=%0d: issued=%0d done=%0d, want %0d",
               n, issued, completed, nblk);
    end
    checks++;
    if (kernel_cycles !== CB'(busy_cnt)) begin
      fails++;
      $display("FAIL kernel_cycles n=%0d: got %0d, want %0d",
               n, kernel_cycles, busy_cnt);
    end
    checks++;
    if (core_reset !== '1 || core_start !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_outputs: rst=%b st=%b busy=%b, want 11 00 0",
               core_reset, core_start, busy);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || core_start !== '0) begin
        fails++;
        $display("FAIL done_hold: done=%b busy=%b st=%b, want 1 0 00",
                 done, busy, core_start);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_release: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    core_done    = '0;
    thread_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset_state");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_launch(8, 0, 0, 1'b0);
    checks++;
    if (assign_at[0] !== 2 || assign_at[1] !== 2) begin
      fails++;
      $display("FAIL basic_assign_time: %0d %0d, want 2 2",
               assign_at[0], assign_at[1]);
    end
    checks++;
    if (done_at !== 4 || kernel_cycles !== 32'd2) begin
      fails++;
      $display("FAIL basic_timing: done_at=%0d kc=%0d, want 4 2",
               done_at, kernel_cycles);
    end
  endtask

  task automatic test_uneven();
    run_launch(10, 3, 0, 1'b0);
    checks++;
    if (assign_at[2] !== 4) begin
      fails++;
      $display("FAIL reassign_time: block2 at %0d, want 4", assign_at[2]);
    end
    checks++;
    if (done_at !== 7 || kernel_cycles !== 32'd5) begin
      fails++;
      $display("FAIL uneven_timing: done_at=%0d kc=%0d, want 7 5",
               done_at, kernel_cycles);
    end
  endtask

  task automatic test_zero();
    run_launch(0, 0, 0, 1'b0);
    checks++;
    if (done_at !== 2 || kernel_cycles !== 32'd0) begin
      fails++;
      $display("FAIL zero_launch: done_at=%0d kc=%0d, want 2 0",
               done_at, kernel_cycles);
    end
  endtask

  task automatic test_back_to_back();
    run_launch(16, 0, 0, 1'b0);
    checks++;
    if (assign_at[0] !== 2 || assign_at[1] !== 2 ||
        assign_at[2] !== 4 || assign_at[3] !== 4) begin
      fails++;
      $display("FAIL simul_assign: %0d %0d %0d %0d, want 2 2 4 4",
               assign_at[0], assign_at[1], assign_at[2], assign_at[3]);
    end
    checks++;
    if (done_at !== 6 || kernel_cycles !== 32'd4) begin
      fails++;
      $display("FAIL simul_timing: done_at=%0d kc=%0d, want 6 4",
               done_at, kernel_cycles);
    end
  endtask

  task automatic test_abort();
    thread_count = TCB'(12);
    start        = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre_busy: busy=%b, want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 2'b11) begin
      fails++;
      $display("FAIL abort_pre_start: st=%b, want 11", core_start);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (core_start !== 2'b00 || core_reset !== 2'b11 || aborted !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0 || kernel_cycles !== 32'd1) begin
      fails++;
      $display("FAIL abort_run: st=%b rst=%b ab=%b busy=%b done=%b kc=%0d, want 00 11 1 0 0 1",
               core_start, core_reset, aborted, busy, done, kernel_cycles);
    end
    @(negedge clk);
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b0 || kernel_cycles !== 32'd1) begin
      fails++;
      $display("FAIL abort_pulse_end: ab=%b busy=%b kc=%0d, want 0 0 1",
               aborted, busy, kernel_cycles);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: ab=%b busy=%b, want 1 0", aborted, busy);
    end
    @(negedge clk);
    run_launch(4, 1, 1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    thread_count = TCB'(20);
    start        = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || core_start !== 2'b11) begin
      fails++;
      $display("FAIL mid_run_pre: busy=%b st=%b, want 1 11", busy, core_start);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset_mid_run");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      run_launch(int'($urandom_range(0, 60)), 0, 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_uneven();
    test_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/block_scheduler.md
Name: block_scheduler

Overview:
- Parametrised successor to the kernel dispatcher in the GPU top level.
- Splits a launch of thread_count threads into blocks of THREADS_PER_BLOCK threads.
- Hands blocks to any free compute core, and drives each core's reset/start/block_id/thread_count.
- Adds over the previous generation: wide thread counts, launch abort, a start/done level handshake that allows relaunch, and a kernel cycle counter.

Parameters:
- NUM_CORES, 2, number of compute cores scheduled.
- THREADS_PER_BLOCK, 4, threads per block; must be a power of two, >=1.
- THREAD_COUNT_BITS, 16, width of thread_count.
- BLOCK_ID_BITS, 8, width of each core_block_id.
- CYCLE_BITS, 32, width of kernel_cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level launch request.
- abort  in  1  cancel the current launch.
- thread_count  in  THREAD_COUNT_BITS  total threads; sampled on launch.
- core_done  in  NUM_CORES  per-core block-finished.
- core_start  out  NUM_CORES  per-core run enable.
- core_reset  out  NUM_CORES  per-core reset.
- core_block_id  out  BLOCK_ID_BITS x NUM_CORES (unpacked)  block index given to each core.
- core_thread_count  out  $clog2(THREADS_PER_BLOCK)+1 x NUM_CORES (unpacked)  active threads in that block.
- done  out  1  launch complete.
- busy  out  1  high while in RUN.
- aborted  out  1  one-cycle pulse on abort.
- kernel_cycles  out  CYCLE_BITS  cycles spent in RUN for the last launch.

Behaviour:
- Reset: state IDLE; core_reset all ones; core_start, done, busy, aborted = 0; core_block_id, core_thread_count, kernel_cycles = 0; internal counters = 0.
- States: IDLE, RUN, DONE. Registered outputs; busy = (state==RUN).
- IDLE:
  - core_reset all ones, core_start all zero.
  - If start=1: latch thread_count; total_blocks = ceil(thread_count/THREADS_PER_BLOCK), computed by shift plus remainder check; clear next_block, blocks_done, kernel_cycles.
  - Then go to RUN, or directly to DONE if total_blocks==0.
- RUN:
  - kernel_cycles increments every cycle, saturating at all ones.
  - Each core i is evaluated every cycle, all cores in parallel.
  - (a) If core_reset[i]=1: core_reset[i]<=0.
    - If next_block+k < total_blocks: core_start[i]<=1; core_block_id[i]<=next_block+k; core_thread_count[i]<=min(THREADS_PER_BLOCK, latched_count - (next_block+k)*THREADS_PER_BLOCK).
    - k = number of lower-index cores assigned in the same cycle. Lowest index receives the lowest block id.
    - next_block advances by the number assigned.
  - (b) Else if core_start[i]=1 and core_done[i]=1: core_start[i]<=0; core_reset[i]<=1; that core counts as one finished block.
  - core_done is ignored on cores that have core_start=0.
  - blocks_done adds all completions in the cycle. Simultaneous completions on every core are all counted.
  - When the updated blocks_done == total_blocks, enter DONE the next cycle.
  - A freed core gets its reset pulse for one cycle and is reassigned on the following cycle. Minimum block turnaround is therefore 2 cycles after core_done.
- DONE:
  - done=1; core_reset all ones; core_start all zero; kernel_cycles held.
  - Stays in DONE while start=1. When start=0: done<=0 and go to IDLE.
  - kernel_cycles stays valid until the next launch.
- abort:
  - Highest priority, any state, above start.
  - Next cycle: IDLE, core_start all zero, core_reset all ones, done=0, aborted=1 for exactly one cycle.
  - kernel_cycles frozen at the abort value.
  - abort in IDLE still pulses aborted.
- Widths: block ids are truncated to BLOCK_ID_BITS. Integrators keep ceil((2^THREAD_COUNT_BITS-1)/THREADS_PER_BLOCK) <= 2^BLOCK_ID_BITS.
- thread_count changes after launch have no effect on the current launch.

Test Plan (NUM_CORES=2, THREADS_PER_BLOCK=4):
1. start=1, thread_count=8:
   - RUN 1 cycle later.
   - Next cycle: core_start=11, block_id={0,1}, thread_count={4,4}.
   - Pulse core_done=11 -> core_reset=11 next cycle; DONE (done=1) the cycle after.
2. thread_count=10, core1 finishes first:
   - Block 2 (thread_count=2) goes to core1 two cycles after its core_done.
   - done only after all 3 blocks complete; kernel_cycles equals the RUN cycle count.
3. thread_count=0:
   - done=1 two cycles after start; core_start never asserted; kernel_cycles=0.
4. thread_count=16 with core_done=11 in the same cycle each round:
   - Both completions counted; block ids 0,1 then 2,3; done after 4 blocks.
5. Abort during RUN with thread_count=12:
   - abort=1 -> next cycle core_start=00, core_reset=11, aborted pulses 1 cycle, busy=0.
   - A fresh start with thread_count=4 then completes normally with block_id 0.
6. Handshake and reset:
   - Hold start=1 after done: done stays 1 and no relaunch occurs.
   - Drop start -> done=0, IDLE.
   - Assert reset mid-RUN -> all outputs return to reset values the next cycle.
